// File: rtl/intel8085_system.sv
// 8085 bus monitor: address latch, machine-cycle decode, instruction register and MOV decode.
// Optional register file with MOV execution and debug readback is enabled by defining I8085_REGFILE_EN.
module intel8085_system #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dbus_to_instr_reg,
  input  logic              ALE,
  input  logic              RDn,
  input  logic              WRn,
  input  logic              IOMn,
  input  logic              S1,
  input  logic              S0,
  input  logic [DATA_W-1:0] laddress_data,
  input  logic [DATA_W-1:0] haddress,
  input  logic [2:0]        dbg_sel,
  output logic [15:0]       address,
  output logic [2:0]        cycle_type,
  output logic [DATA_W-1:0] instr,
  output logic              ir_valid,
  output logic              is_mov,
  output logic              is_halt,
  output logic [2:0]        mov_dst,
  output logic [2:0]        mov_src,
  output logic [DATA_W-1:0] dbg_data
);

  // A floating IO/M line reads as an I/O cycle; unknown status bits fall to the idle default.
  logic iom_eff;
  assign iom_eff = (IOMn === 1'b0) ? 1'b0 : 1'b1;

  always_comb begin
    cycle_type = 3'd0;
    case ({iom_eff, S1, S0})
      3'b011:  cycle_type = 3'd1;
      3'b010:  cycle_type = 3'd2;
      3'b001:  cycle_type = 3'd3;
      3'b110:  cycle_type = 3'd4;
      3'b101:  cycle_type = 3'd5;
      3'b000:  cycle_type = 3'd6;
      default: cycle_type = 3'd0;
    endcase
  end

  // Strobes are observed only, never used to qualify loads.
  logic unused_strobes;
  assign unused_strobes = ^{RDn, WRn};

  assign is_halt = (instr == 8'h76);
  assign is_mov  = (instr[7:6] == 2'b01) && !is_halt;
  assign mov_dst = instr[5:3];
  assign mov_src = instr[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      address  <= 16'h0000;
      instr    <= '0;
      ir_valid <= 1'b0;
    end else begin
      if (ALE)
        address <= {haddress, laddress_data};
      if (dbus_to_instr_reg) begin
        instr    <= laddress_data;
        ir_valid <= 1'b1;
      end else begin
        ir_valid <= 1'b0;
      end
    end
  end

`ifdef I8085_REGFILE_EN
  logic [DATA_W-1:0] regs [8];
  logic              exec;

  assign exec = ir_valid && !dbus_to_instr_reg && is_mov &&
                (mov_dst != 3'd6) && (mov_src != 3'd6);

  always_ff @(posedge clk) begin
    if (rst) begin
      regs[0] <= 8'h10;
      regs[1] <= 8'h11;
      regs[2] <= 8'h12;
      regs[3] <= 8'h13;
      regs[4] <= 8'h14;
      regs[5] <= 8'h15;
      regs[6] <= 8'h00;
      regs[7] <= 8'h17;
    end else if (exec) begin
      regs[mov_dst] <= regs[mov_src];
    end
  end

  assign dbg_data = (dbg_sel == 3'd6) ? '0 : regs[dbg_sel];
`else
  logic [2:0] unused_dbg_sel;
  assign unused_dbg_sel = dbg_sel;
  assign dbg_data       = '0;
`endif

endmodule

// File: tb/tb_intel8085_system.sv
// Self-checking bench for intel8085_system: cycle-type table, directed sequences and a random run
// compared against a behavioural model of the bus monitor and register file.
module tb_intel8085_system;

  logic        clk = 1'b0;
  logic        rst, dbus_to_instr_reg, ALE, RDn, WRn, IOMn, S1, S0;
  logic [7:0]  laddress_data, haddress, instr, dbg_data;
  logic [2:0]  dbg_sel, cycle_type, mov_dst, mov_src;
  logic [15:0] address;
  logic        ir_valid, is_mov, is_halt;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [15:0] m_addr;
  logic [7:0]  m_instr;
  logic        m_irv;
  logic [7:0]  m_regs [8];
  logic [2:0]  ct_map [8];

  intel8085_system dut (
    .clk(clk), .rst(rst), .dbus_to_instr_reg(dbus_to_instr_reg), .ALE(ALE),
    .RDn(RDn), .WRn(WRn), .IOMn(IOMn), .S1(S1), .S0(S0),
    .laddress_data(laddress_data), .haddress(haddress), .dbg_sel(dbg_sel),
    .address(address), .cycle_type(cycle_type), .instr(instr), .ir_valid(ir_valid),
    .is_mov(is_mov), .is_halt(is_halt), .mov_dst(mov_dst), .mov_src(mov_src),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iomn, s1, s0;
    logic [2:0] ct;
  } ct_vec_t;

  typedef struct {
    logic [7:0] op;
    logic       mov, halt;
  } dec_vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_dbg(input logic [2:0] sel);
`ifdef I8085_REGFILE_EN
    return (sel == 3'd6) ? 8'h00 : m_regs[sel];
`else
    return 8'h00;
`endif
  endfunction

  task automatic model_edge();
    int op, dst, src;
    if (rst) begin
      m_addr = 16'h0000; m_instr = 8'h00; m_irv = 1'b0;
      for (int i = 0; i < 8; i++) m_regs[i] = (i == 6) ? 8'h00 : 8'(16 + i);
    end else begin
      if (ALE) m_addr = {haddress, laddress_data};
      if (dbus_to_instr_reg) begin
        m_instr = laddress_data; m_irv = 1'b1;
      end else if (m_irv) begin
        op = m_instr; dst = (op / 8) % 8; src = op % 8;
        if (op / 64 == 1 && op != 'h76 && dst != 6 && src != 6)
          m_regs[dst] = m_regs[src];
        m_irv = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic compare_all();
    int op;
    op = m_instr;
    chk("address", address, m_addr);
    chk("cycle_type", {13'd0, cycle_type}, {13'd0, ct_map[{(IOMn !== 1'b0), S1, S0}]});
    chk("instr", {8'd0, instr}, {8'd0, m_instr});
    chk("ir_valid", {15'd0, ir_valid}, {15'd0, m_irv});
    chk("is_mov", {15'd0, is_mov}, {15'd0, (op / 64 == 1) && (op != 'h76)});
    chk("is_halt", {15'd0, is_halt}, {15'd0, op == 'h76});
    chk("mov_dst", {13'd0, mov_dst}, 16'((op / 8) % 8));
    chk("mov_src", {13'd0, mov_src}, 16'(op % 8));
    chk("dbg_data", {8'd0, dbg_data}, {8'd0, exp_dbg(dbg_sel)});
  endtask

  task automatic idle();
    rst = 0; dbus_to_instr_reg = 0; ALE = 0; RDn = 1; WRn = 1;
    IOMn = 1; S1 = 0; S0 = 0;
  endtask

  task automatic load(input logic [7:0] op);
    laddress_data = op; RDn = 0; dbus_to_instr_reg = 1;
    tick();
    dbus_to_instr_reg = 0; RDn = 1;
  endtask

  ct_vec_t  ct_tbl [8];
  dec_vec_t dec_tbl [6];

  initial begin
    ct_map = '{3'd6, 3'd3, 3'd2, 3'd1, 3'd0, 3'd5, 3'd4, 3'd0};
    ct_tbl = '{'{0,0,0,3'd6}, '{0,0,1,3'd3}, '{0,1,0,3'd2}, '{0,1,1,3'd1},
               '{1,0,0,3'd0}, '{1,0,1,3'd5}, '{1,1,0,3'd4}, '{1,1,1,3'd0}};
    dec_tbl = '{'{8'h40,1,0}, '{8'h76,0,1}, '{8'h7F,1,0},
                '{8'h80,0,0}, '{8'h3F,0,0}, '{8'h7E,1,0}};
    laddress_data = 8'h00; haddress = 8'h00; dbg_sel = 3'd3;

    // Reset, then idle bus
    idle(); rst = 1; tick();
    rst = 0; tick();
    chk("rst_address", address, 16'h0000);
    chk("rst_instr", {8'd0, instr}, 16'h0000);
    chk("rst_ir_valid", {15'd0, ir_valid}, 16'h0000);
    chk("rst_cycle_type", {13'd0, cycle_type}, 16'h0000);
`ifdef I8085_REGFILE_EN
    chk("rst_dbg_e", {8'd0, dbg_data}, 16'h0013);
`else
    chk("rst_dbg_tied", {8'd0, dbg_data}, 16'h0000);
`endif

    // Cycle-type decode table
    for (int i = 0; i < 8; i++) begin
      IOMn = ct_tbl[i].iomn; S1 = ct_tbl[i].s1; S0 = ct_tbl[i].s0;
      #1;
      chk($sformatf("ct_tbl%0d", i), {13'd0, cycle_type}, {13'd0, ct_tbl[i].ct});
    end

    // Opcode fetch address latch
    IOMn = 0; S1 = 1; S0 = 1; ALE = 1; haddress = 8'h20; laddress_data = 8'h05;
    tick();
    ALE = 0; laddress_data = 8'hAA;
    tick();
    chk("latch_address", address, 16'h2005);
    chk("latch_ct", {13'd0, cycle_type}, 16'd1);

    // MOV B,E then execution one edge later
    dbg_sel = 3'd0;
    load(8'h43);
    chk("mov_instr", {8'd0, instr}, 16'h0043);
    chk("mov_is_mov", {15'd0, is_mov}, 16'd1);
    chk("mov_dst", {13'd0, mov_dst}, 16'd0);
    chk("mov_src", {13'd0, mov_src}, 16'd3);
    chk("mov_irv_set", {15'd0, ir_valid}, 16'd1);
    tick();
    chk("mov_irv_clr", {15'd0, ir_valid}, 16'd0);
    chk("mov_b", {8'd0, dbg_data}, {8'd0, exp_dbg(3'd0)});
`ifdef I8085_REGFILE_EN
    chk("mov_b_const", {8'd0, dbg_data}, 16'h0013);
`endif

    // HLT is a no-op
    load(8'h76);
    chk("hlt_is_halt", {15'd0, is_halt}, 16'd1);
    chk("hlt_is_mov", {15'd0, is_mov}, 16'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i); #1;
      chk($sformatf("hlt_reg%0d", i), {8'd0, dbg_data}, {8'd0, exp_dbg(3'(i))});
    end

    // MOV A,M is unsupported
    dbg_sel = 3'd7;
    load(8'h7E);
    tick();
    chk("movm_irv", {15'd0, ir_valid}, 16'd0);
    chk("movm_a", {8'd0, dbg_data}, {8'd0, exp_dbg(3'd7)});

    // Reset discards a pending MOV B,E
    dbg_sel = 3'd0;
    rst = 1; tick(); rst = 0;
    load(8'h43);
    rst = 1; tick(); rst = 0;
    chk("rstmid_instr", {8'd0, instr}, 16'h0000);
    chk("rstmid_irv", {15'd0, ir_valid}, 16'd0);
`ifdef I8085_REGFILE_EN
    chk("rstmid_b", {8'd0, dbg_data}, 16'h0010);
`endif

    // Held load keeps re-loading and defers MOV B,C
    laddress_data = 8'h41; dbus_to_instr_reg = 1;
    tick(); tick();
    chk("hold_irv", {15'd0, ir_valid}, 16'd1);
    chk("hold_b", {8'd0, dbg_data}, {8'd0, exp_dbg(3'd0)});
    dbus_to_instr_reg = 0;
    tick();
    chk("release_b", {8'd0, dbg_data}, {8'd0, exp_dbg(3'd0)});
`ifdef I8085_REGFILE_EN
    chk("release_b_const", {8'd0, dbg_data}, 16'h0011);
`endif

    // Decode table
    for (int i = 0; i < 6; i++) begin
      load(dec_tbl[i].op);
      chk($sformatf("dec_mov_%h", dec_tbl[i].op), {15'd0, is_mov}, {15'd0, dec_tbl[i].mov});
      chk($sformatf("dec_halt_%h", dec_tbl[i].op), {15'd0, is_halt}, {15'd0, dec_tbl[i].halt});
      tick();
    end

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      rst               = ($urandom_range(0, 39) == 0);
      ALE               = 1'($urandom);
      dbus_to_instr_reg = ($urandom_range(0, 2) == 0);
      RDn               = 1'($urandom);
      WRn               = 1'($urandom);
      IOMn              = 1'($urandom);
      S1                = 1'($urandom);
      S0                = 1'($urandom);
      haddress          = 8'($urandom);
      laddress_data     = $urandom_range(0, 1) ? {2'b01, 6'($urandom)} : 8'($urandom);
      dbg_sel           = 3'($urandom);
      tick();
      compare_all();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
